operand_entry: RTL and testbench
================================

# operand_entry

Debounced operand-entry stage that sits directly upstream of `fullAdder_4b`. It conditions raw board inputs (a 4-bit switch bank and three pushbuttons) and drives the adder's `a`, `b` and `cin` from registered, glitch-free values. It also emits a one-cycle `upd` pulse whenever any operand changes, for display refresh or logging.

## Interface
Parameters:
- `DEB_CYCLES`, 500000 — consecutive stable cycles before a button level is accepted (10 ms at 50 MHz); legal ≥ 2.
- `REPEAT_CYCLES`, 25000000 — hold-repeat period; used only with `OPERAND_ENTRY_REPEAT_EN`; legal ≥ 2.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `sw`  input  4  raw switch bank; asynchronous; sampled through a 2-FF synchronizer.
- `btn_a`  input  1  raw pushbutton, active-high; loads `sw` into `a`.
- `btn_b`  input  1  raw pushbutton, active-high; loads `sw` into `b`.
- `btn_cin`  input  1  raw pushbutton, active-high; toggles `cin`.
- `a`  output  4  registered operand A to the adder.
- `b`  output  4  registered operand B to the adder.
- `cin`  output  1  registered carry-in to the adder.
- `upd`  output  1  one-cycle pulse in the same cycle any of `a`, `b` or `cin` takes a new value.

## Operation
- Every raw input passes through its own 2-FF synchronizer.
- Each button has an independent debouncer with counter `cnt` (width `$clog2(DEB_CYCLES)`) and level `deb`:
  - synced == `deb`: `cnt` ← 0.
  - synced != `deb` and `cnt` < `DEB_CYCLES-1`: `cnt` increments.
  - synced != `deb` and `cnt` == `DEB_CYCLES-1`: `deb` flips and `cnt` ← 0.
  - Any bounce shorter than `DEB_CYCLES` cycles restarts the count and has no effect.
- Rising edge of `deb` is `rise = deb & ~deb_q`. Release is debounced the same way but triggers no action.
- Actions on `rise`:
  - `btn_a`: `a` ← synced `sw`.
  - `btn_b`: `b` ← synced `sw`.
  - `btn_cin`: `cin` ← `~cin`.
- Simultaneous rises: all actions occur in the same cycle. `a` and `b` both load the same `sw` value. A single `upd` pulse is issued.
- A load that writes the value already held still pulses `upd`.
- Reset values: `a`=0, `b`=0, `cin`=0, `upd`=0, all synchronizers, `deb`, `deb_q` and counters 0.
- Reset asserted mid-debounce or mid-repeat aborts the operation. After release, a button still held counts as a new press (a full `DEB_CYCLES` is required).

## Timing
- Latency is counted from the first rising `clk` edge that samples a button high. The synced level is high after edge 2.
- `deb` rises at edge `DEB_CYCLES+2`.
- `a`/`b`/`cin` update and `upd` is high at edge `DEB_CYCLES+3` (7 cycles for `DEB_CYCLES`=4).
- `sw` is sampled as its synced value in the cycle `rise` is high.
- `upd` is high for exactly one cycle per update event.

## Configuration
- `OPERAND_ENTRY_REPEAT_EN` defined: hold-repeat on `btn_a` and `btn_b`.
  - While `deb` stays high, a per-button repeat counter runs from the initial load.
  - Every `REPEAT_CYCLES` cycles the operand increments by 1, modulo 16 (15 → 0 wraps), with an `upd` pulse.
  - Falling `deb` clears the counter.
  - `btn_cin` never repeats.
- Undefined: no repeat logic is compiled in; holding a button produces exactly one action.

## Test plan
Bench uses a 20 ns clock, `DEB_CYCLES`=4 and `REPEAT_CYCLES`=8.
- Reset low for 3 cycles, then high -> `a`=0, `b`=0, `cin`=0, `upd`=0 throughout.
- `sw`=4'd3, `btn_a` held high for 20 cycles -> `a`=3 exactly 7 cycles after first sample; one `upd` pulse; `b`, `cin` unchanged (repeat macro undefined).
- `btn_b` toggling every 2 cycles for 12 cycles, then released -> `b` unchanged, no `upd`.
- `sw`=4'd2, `btn_a` and `btn_b` rise in the same cycle -> `a`=2, `b`=2 in the same cycle; single `upd`.
- `btn_cin` pressed twice (each held 10 cycles, 10-cycle gap) -> `cin` 0→1→0; two `upd` pulses.
- With `OPERAND_ENTRY_REPEAT_EN` and `a` loaded with 14 via `sw`=4'd14, `btn_a` held 30 cycles -> `a` = 14, 15, 0, 1 at 8-cycle spacing; one `upd` per step; reset asserted mid-hold -> `a`=0 immediately.

Source files
------------

// File: rtl/operand_entry.sv
// Debounced operand-entry stage feeding fullAdder_4b: synchronizes switches and buttons,
// registers a/b/cin and pulses upd on every update. Define OPERAND_ENTRY_REPEAT_EN for hold-repeat on a/b.
module operand_entry #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_cin,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic       upd
);

  localparam int                CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]     CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam int                BTN_A   = 0;
  localparam int                BTN_B   = 1;
  localparam int                BTN_CIN = 2;

  if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("operand_entry: DEB_CYCLES and REPEAT_CYCLES must both be >= 2");
  end

  logic [3:0]    r_sw_s1, r_sw_s2;
  logic [2:0]    r_btn_s1, r_btn_s2;
  logic [2:0]    r_deb, r_deb_q;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_btn_raw;
  logic [2:0]    w_rise;

  logic [3:0]    r_a, r_b;
  logic          r_cin, r_upd;
  logic [3:0]    w_a_nxt, w_b_nxt;
  logic          w_cin_nxt, w_upd_nxt;

  assign w_btn_raw = {btn_cin, btn_b, btn_a};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the small counter array is reset like any other register so an aborted debounce restarts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_deb    <= '0;
      r_deb_q  <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_deb_q  <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_q;

`ifdef OPERAND_ENTRY_REPEAT_EN
  localparam int            RW      = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep_cnt [2];
  logic [1:0]    w_held;
  logic [1:0]    w_rep_fire;

  // Held means debounced high past the rise cycle, so the initial load restarts the period.
  assign w_held = r_deb[1:0] & r_deb_q[1:0];

  always_comb begin
    for (int i = 0; i < 2; i++) w_rep_fire[i] = w_held[i] && (r_rep_cnt[i] == REP_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_held[i] || w_rep_fire[i]) r_rep_cnt[i] <= '0;
        else                             r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
      end
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_cin_nxt = r_cin;
    w_upd_nxt = 1'b0;
    if (w_rise[BTN_A]) begin
      w_a_nxt   = r_sw_s2;
      w_upd_nxt = 1'b1;
    end
    if (w_rise[BTN_B]) begin
      w_b_nxt   = r_sw_s2;
      w_upd_nxt = 1'b1;
    end
    if (w_rise[BTN_CIN]) begin
      w_cin_nxt = ~r_cin;
      w_upd_nxt = 1'b1;
    end
`ifdef OPERAND_ENTRY_REPEAT_EN
    if (w_rep_fire[BTN_A]) begin
      w_a_nxt   = r_a + 4'd1;
      w_upd_nxt = 1'b1;
    end
    if (w_rep_fire[BTN_B]) begin
      w_b_nxt   = r_b + 4'd1;
      w_upd_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_upd <= 1'b0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_cin <= w_cin_nxt;
      r_upd <= w_upd_nxt;
    end
  end

  assign a   = r_a;
  assign b   = r_b;
  assign cin = r_cin;
  assign upd = r_upd;

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry with DEB_CYCLES=4, REPEAT_CYCLES=8.
// Expected values are hand-computed from the debounce/repeat timing.
module tb_operand_entry;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       btn_a, btn_b, btn_cin;
  logic [3:0] a, b;
  logic       cin, upd;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

`ifdef OPERAND_ENTRY_REPEAT_EN
  // 20-cycle hold: load 3 at edge 7, repeats at edges 15 and 23.
  localparam logic [3:0] EXP1_A   = 4'd5;
  localparam int         EXP1_UPD = 3;
`else
  localparam logic [3:0] EXP1_A   = 4'd3;
  localparam int         EXP1_UPD = 1;
`endif

  operand_entry #(.DEB_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .btn_cin (btn_cin),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .upd     (upd)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n clock edges, sampling 1 ns after each one and counting upd pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upd === 1'b1) upd_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; sw = '0; btn_a = 0; btn_b = 0; btn_cin = 0;

    // Reset state
    step(3);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_cin", cin, 0);
    check("rst_upd", upd, 0);
    reset = 1'b1;
    step(2);
    check("post_rst_a", a, 0);
    check("post_rst_upd", upd, 0);

    // Single press of btn_a: load 3 exactly at edge 7
    upd_cnt = 0;
    sw = 4'd3; btn_a = 1'b1;
    step(6);
    check("a_before_lat", a, 0);
    check("upd_before_lat", upd, 0);
    step(1);
    check("a_at_lat", a, 3);
    check("upd_at_lat", upd, 1);
    step(13);
    btn_a = 1'b0;
    step(10);
    check("a_after_hold", a, EXP1_A);
    check("upd_cnt_hold", upd_cnt, EXP1_UPD);
    check("b_untouched", b, 0);
    check("cin_untouched", cin, 0);

    // Bouncing btn_b: never stable 4 cycles, no effect
    upd_cnt = 0;
    sw = 4'd5;
    for (int k = 0; k < 3; k++) begin
      btn_b = 1'b1; step(2);
      btn_b = 1'b0; step(2);
    end
    step(10);
    check("bounce_b", b, 0);
    check("bounce_upd", upd_cnt, 0);

    // Simultaneous a/b press: both load 2 in one cycle, single upd
    upd_cnt = 0;
    sw = 4'd2; btn_a = 1'b1; btn_b = 1'b1;
    step(6);
    check("sim_a_before", a, EXP1_A);
    check("sim_b_before", b, 0);
    step(1);
    check("sim_a", a, 2);
    check("sim_b", b, 2);
    check("sim_upd", upd, 1);
    step(1);
    btn_a = 1'b0; btn_b = 1'b0;
    step(10);
    check("sim_upd_cnt", upd_cnt, 1);

    // btn_cin pressed twice: toggles 0->1->0
    upd_cnt = 0;
    btn_cin = 1'b1;
    step(6);
    check("cin_before", cin, 0);
    step(1);
    check("cin_first", cin, 1);
    step(3);
    btn_cin = 1'b0;
    step(10);
    btn_cin = 1'b1;
    step(7);
    check("cin_second", cin, 0);
    step(3);
    btn_cin = 1'b0;
    step(10);
    check("cin_upd_cnt", upd_cnt, 2);
    check("cin_a_kept", a, 2);

    // Long hold of btn_a with sw=14
    upd_cnt = 0;
    sw = 4'd14; btn_a = 1'b1;
    step(7);
    check("hold_load", a, 14);
`ifdef OPERAND_ENTRY_REPEAT_EN
    step(8);
    check("rep_15", a, 15);
    check("rep_15_upd", upd, 1);
    step(8);
    check("rep_wrap_0", a, 0);
    step(7);
    btn_a = 1'b0;
    step(1);
    check("rep_1", a, 1);
    step(10);
    check("rep_final", a, 1);
    check("rep_upd_cnt", upd_cnt, 4);
`else
    step(23);
    btn_a = 1'b0;
    step(11);
    check("norep_final", a, 14);
    check("norep_upd_cnt", upd_cnt, 1);
`endif

    // Reset mid-hold clears a at once; still-held button is a new press afterwards
    sw = 4'd6; btn_a = 1'b1;
    step(12);
    check("mid_hold_a", a, 6);
    reset = 1'b0;
    #1;
    check("async_rst_a", a, 0);
    check("async_rst_upd", upd, 0);
    step(2);
    reset = 1'b1;
    sw = 4'd9;
    upd_cnt = 0;
    step(6);
    check("repress_before", a, 0);
    step(1);
    check("repress_load", a, 9);
    check("repress_upd", upd, 1);
    btn_a = 1'b0;
    step(10);

    // Loading the value already held still pulses upd
    upd_cnt = 0;
    btn_a = 1'b1;
    step(7);
    check("same_val_a", a, 9);
    check("same_val_upd", upd, 1);
    btn_a = 1'b0;
    step(10);
    check("same_val_cnt", upd_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
